// File: rtl/ebox_mreq.sv
// ebox_mreq: EBOX-side memory request sequencer.
// Converts one-cycle microcode start strobes into held mbox requests.
// It runs read, write and read-pause-write cycles, captures read data into MB,
// and reports completion or timeout back to the EBOX.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no cycle in flight; starts accepted, address/data held
// RD_WAIT | req+read asserted, waiting for ack (PSE set for RPW)
// PAUSE   | read half of RPW done; req low, PSE high, wait for finishWrite
// WR_WAIT | req+write asserted, waiting for ack
module ebox_mreq #(
    parameter int FIXED_LAT = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic         eboxClk,
    input  logic         eboxResetN,
    input  logic         startRead,
    input  logic         startWrite,
    input  logic         startRPW,
    input  logic         finishWrite,
    input  logic [13:35] vmaIn,
    input  logic         acRefIn,
    input  logic [0:35]  wrData,
    input  logic         memAck,
    input  logic [0:35]  cacheDataRead,
    output logic [13:35] EBOX_VMA,
    output logic         vmaACRef,
    output logic         req,
    output logic         read,
    output logic         write,
    output logic         PSE,
    output logic [0:35]  cacheDataWrite,
    output logic [0:35]  mbData,
    output logic         busy,
    output logic         done,
    output logic         timeoutErr
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, PAUSE, WR_WAIT} state_t;

    // Terminal counts of the shared wait counter (cycles since entering a wait state).
    localparam logic [9:0] LAT_TC = 10'((FIXED_LAT > 0) ? FIXED_LAT - 1 : 0);
    localparam logic [9:0] TO_TC  = 10'(TIMEOUT - 1);

    logic [1:0] rst_pipe;
    logic       rst_n;
    state_t     state;
    logic       rpw;
    logic [9:0] wait_cnt;
    logic       ack;
    logic       tmo;

    // Reset asserts immediately but releases two clocks after eboxResetN rises.
    always_ff @(posedge eboxClk or negedge eboxResetN) begin
        if (!eboxResetN) rst_pipe <= 2'b00;
        else             rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    // Internal ack fires on the FIXED_LAT-th edge after req rises; otherwise memAck is used.
    assign ack = (FIXED_LAT > 0) ? (wait_cnt == LAT_TC) : memAck;
    assign tmo = (wait_cnt == TO_TC);

    // Sequencer FSM with all mbox qualifiers and status outputs registered.
    always_ff @(posedge eboxClk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rpw            <= 1'b0;
            wait_cnt       <= '0;
            EBOX_VMA       <= '0;
            vmaACRef       <= 1'b0;
            req            <= 1'b0;
            read           <= 1'b0;
            write          <= 1'b0;
            PSE            <= 1'b0;
            cacheDataWrite <= '0;
            mbData         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeoutErr     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startRPW || startRead || startWrite) begin
                        EBOX_VMA   <= vmaIn;
                        vmaACRef   <= acRefIn;
                        timeoutErr <= 1'b0;
                        wait_cnt   <= '0;
                        busy       <= 1'b1;
                        req        <= 1'b1;
                        if (startRPW || startRead) begin
                            state <= RD_WAIT;
                            rpw   <= startRPW;
                            read  <= 1'b1;
                            PSE   <= startRPW;
                        end else begin
                            state          <= WR_WAIT;
                            rpw            <= 1'b0;
                            write          <= 1'b1;
                            PSE            <= 1'b0;
                            cacheDataWrite <= wrData;
                        end
                    end
                end
                RD_WAIT: begin
                    if (ack) begin
                        mbData   <= cacheDataRead;
                        done     <= 1'b1;
                        req      <= 1'b0;
                        read     <= 1'b0;
                        wait_cnt <= '0;
                        if (rpw) begin
                            state <= PAUSE;
                            PSE   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            PSE   <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end else if (tmo) begin
                        state      <= IDLE;
                        rpw        <= 1'b0;
                        req        <= 1'b0;
                        read       <= 1'b0;
                        PSE        <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeoutErr <= 1'b1;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                PAUSE: begin
                    // Address stays latched; no counting here so the pause can last indefinitely.
                    if (finishWrite) begin
                        state          <= WR_WAIT;
                        cacheDataWrite <= wrData;
                        req            <= 1'b1;
                        write          <= 1'b1;
                        PSE            <= 1'b0;
                        wait_cnt       <= '0;
                    end
                end
                WR_WAIT: begin
                    if (ack || tmo) begin
                        state      <= IDLE;
                        rpw        <= 1'b0;
                        req        <= 1'b0;
                        write      <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeoutErr <= !ack;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ebox_mreq.sv
// Testbench for ebox_mreq: two instances (internal fixed-latency ack and external memAck
// with a short timeout) share stimulus; a scoreboard checks each done pulse.
module tb_ebox_mreq;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic         s_read, s_write, s_rpw, s_finish;
    logic [13:35] vma_in;
    logic         acref;
    logic [0:35]  wr_data;
    logic         mem_ack;
    logic [0:35]  rd_data;

    logic [13:35] f_vma, a_vma, m_vma;
    logic [0:35]  f_cdw, a_cdw, m_cdw, f_mb, a_mb, m_mb;
    logic         f_acref, f_req, f_read, f_write, f_pse, f_busy, f_done, f_to;
    logic         a_acref, a_req, a_read, a_write, a_pse, a_busy, a_done, a_to;
    logic         m_acref, m_req, m_read, m_write, m_pse, m_busy, m_done, m_to;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [35:0] mb;
        logic [35:0] cdw;
        logic [22:0] vma;
        logic        acref;
        logic        to;
        logic        busy;
        int          rd;
        int          wr;
        int          pse;
        int          pause;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   c_rd, c_wr, c_pse, c_pause;

    ebox_mreq #(.FIXED_LAT(1), .TIMEOUT(255)) dut_fix (
        .eboxClk(clk), .eboxResetN(rst_n),
        .startRead(s_read & ~sel), .startWrite(s_write & ~sel),
        .startRPW(s_rpw & ~sel), .finishWrite(s_finish & ~sel),
        .vmaIn(vma_in), .acRefIn(acref), .wrData(wr_data),
        .memAck(mem_ack), .cacheDataRead(rd_data),
        .EBOX_VMA(f_vma), .vmaACRef(f_acref), .req(f_req), .read(f_read),
        .write(f_write), .PSE(f_pse), .cacheDataWrite(f_cdw), .mbData(f_mb),
        .busy(f_busy), .done(f_done), .timeoutErr(f_to)
    );

    ebox_mreq #(.FIXED_LAT(0), .TIMEOUT(8)) dut_ack (
        .eboxClk(clk), .eboxResetN(rst_n),
        .startRead(s_read & sel), .startWrite(s_write & sel),
        .startRPW(s_rpw & sel), .finishWrite(s_finish & sel),
        .vmaIn(vma_in), .acRefIn(acref), .wrData(wr_data),
        .memAck(mem_ack), .cacheDataRead(rd_data),
        .EBOX_VMA(a_vma), .vmaACRef(a_acref), .req(a_req), .read(a_read),
        .write(a_write), .PSE(a_pse), .cacheDataWrite(a_cdw), .mbData(a_mb),
        .busy(a_busy), .done(a_done), .timeoutErr(a_to)
    );

    assign m_vma   = sel ? a_vma   : f_vma;
    assign m_cdw   = sel ? a_cdw   : f_cdw;
    assign m_mb    = sel ? a_mb    : f_mb;
    assign m_acref = sel ? a_acref : f_acref;
    assign m_req   = sel ? a_req   : f_req;
    assign m_read  = sel ? a_read  : f_read;
    assign m_write = sel ? a_write : f_write;
    assign m_pse   = sel ? a_pse   : f_pse;
    assign m_busy  = sel ? a_busy  : f_busy;
    assign m_done  = sel ? a_done  : f_done;
    assign m_to    = sel ? a_to    : f_to;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [35:0] mb, input logic [35:0] cdw, input logic [22:0] vma,
                        input logic ac, input logic to, input logic bsy,
                        input int rd, input int wr, input int pse, input int pause);
        exp_t x;
        x.mb = mb; x.cdw = cdw; x.vma = vma; x.acref = ac; x.to = to; x.busy = bsy;
        x.rd = rd; x.wr = wr; x.pse = pse; x.pause = pause;
        sb.push_back(x);
    endtask

    // Strobe is sampled on the edge after the one it follows; returns 1ns after that edge.
    task automatic start(input logic r, input logic w, input logic p, input logic [22:0] v,
                         input logic ac, input logic [35:0] wd, input logic [35:0] rdd);
        @(posedge clk); #1;
        s_read = r; s_write = w; s_rpw = p;
        vma_in = v; acref = ac; wr_data = wd; rd_data = rdd;
        @(posedge clk); #1;
        s_read = 1'b0; s_write = 1'b0; s_rpw = 1'b0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) @(posedge clk);
        #1 mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (m_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, m_busy, k);
        end
    endtask

    // Monitor: accumulate qualifier activity per transaction, compare on each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            c_rd = 0; c_wr = 0; c_pse = 0; c_pause = 0;
        end else begin
            if (m_req && m_read)  c_rd++;
            if (m_req && m_write) c_wr++;
            if (m_req && m_pse)   c_pse++;
            if (!m_req && m_pse)  c_pause++;
            if (m_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no transaction pending");
                end else begin
                    e = sb.pop_front();
                    check("mb_data",     64'(m_mb),    64'(e.mb));
                    check("cache_wdata", 64'(m_cdw),   64'(e.cdw));
                    check("ebox_vma",    64'(m_vma),   64'(e.vma));
                    check("vma_acref",   64'(m_acref), 64'(e.acref));
                    check("timeout_err", 64'(m_to),    64'(e.to));
                    check("busy_at_done", 64'(m_busy), 64'(e.busy));
                    check("read_cycles",  64'(c_rd),    64'(e.rd));
                    check("write_cycles", 64'(c_wr),    64'(e.wr));
                    check("pse_req_cycles", 64'(c_pse), 64'(e.pse));
                    check("pause_cycles", 64'(c_pause), 64'(e.pause));
                end
                c_rd = 0; c_wr = 0; c_pse = 0; c_pause = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        s_read = 1'b0; s_write = 1'b0; s_rpw = 1'b0; s_finish = 1'b0;
        vma_in = '0; acref = 1'b0; wr_data = '0; mem_ack = 1'b0; rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fix_ctl", 64'({f_req, f_read, f_write, f_pse, f_busy, f_done, f_to, f_acref}), 64'd0);
        check("rst_fix_data", 64'(f_mb | f_cdw), 64'd0);
        check("rst_ack_ctl", 64'({a_req, a_read, a_write, a_pse, a_busy, a_done, a_to, a_acref}), 64'd0);
        check("rst_ack_vma", 64'(a_vma), 64'd0);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Fixed latency read, then a back-to-back read accepted right after done.
        push(36'o123456765432, 36'o0, 23'o000100, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
        push(36'o000000000777, 36'o0, 23'o37777777, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
        start(1'b1, 1'b0, 1'b0, 23'o000100, 1'b0, 36'o0, 36'o123456765432);
        start(1'b1, 1'b0, 1'b0, 23'o37777777, 1'b1, 36'o0, 36'o000000000777);
        wait_idle("fix_read_idle");
        repeat (2) @(posedge clk);

        // Read-pause-write with a long pause.
        push(36'o5, 36'o0, 23'o1234, 1'b0, 1'b0, 1'b1, 1, 0, 1, 1);
        push(36'o5, 36'o6, 23'o1234, 1'b0, 1'b0, 1'b0, 0, 1, 0, 10);
        start(1'b0, 1'b0, 1'b1, 23'o1234, 1'b0, 36'o0, 36'o5);
        repeat (11) @(posedge clk);
        #1 s_finish = 1'b1; wr_data = 36'o6;
        @(posedge clk); #1 s_finish = 1'b0;
        wait_idle("rpw_idle");
        repeat (3) @(posedge clk);

        // External ack instance: write with ack on the 5th edge.
        sel = 1'b1;
        repeat (2) @(posedge clk);
        push(36'o0, 36'o777000111222, 23'o2000, 1'b1, 1'b0, 1'b0, 0, 5, 0, 0);
        start(1'b0, 1'b1, 1'b0, 23'o2000, 1'b1, 36'o777000111222, 36'o0);
        ack_after(4);
        wait_idle("write_idle");

        // finishWrite and memAck in IDLE must be ignored.
        @(posedge clk); #1 s_finish = 1'b1; wr_data = 36'o111; mem_ack = 1'b1;
        @(posedge clk); #1 s_finish = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);

        // Timeout: no ack for TIMEOUT cycles, then the next read clears the flag.
        push(36'o0, 36'o777000111222, 23'o3000, 1'b0, 1'b1, 1'b0, 8, 0, 0, 0);
        start(1'b1, 1'b0, 1'b0, 23'o3000, 1'b0, 36'o0, 36'o321);
        wait_idle("timeout_idle");
        repeat (3) @(posedge clk);
        #1 check("timeout_sticky", 64'(m_to), 64'd1);
        push(36'o444, 36'o777000111222, 23'o3001, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0);
        start(1'b1, 1'b0, 1'b0, 23'o3001, 1'b0, 36'o0, 36'o444);
        ack_after(1);
        wait_idle("read_after_timeout_idle");

        // Simultaneous read+write strobes, then a write while busy: only the read runs.
        push(36'o555, 36'o777000111222, 23'o4000, 1'b0, 1'b0, 1'b0, 4, 0, 0, 0);
        start(1'b1, 1'b1, 1'b0, 23'o4000, 1'b0, 36'o222, 36'o555);
        @(posedge clk); #1 s_write = 1'b1; wr_data = 36'o333; vma_in = 23'o5000;
        @(posedge clk); #1 s_write = 1'b0;
        ack_after(1);
        wait_idle("priority_idle");
        repeat (5) @(posedge clk);

        // Asynchronous reset in the middle of a write cycle.
        start(1'b0, 1'b1, 1'b0, 23'o6000, 1'b1, 36'o666, 36'o0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ctl", 64'({m_req, m_read, m_write, m_pse, m_busy, m_done, m_to, m_acref}), 64'd0);
        check("arst_vma", 64'(m_vma), 64'd0);
        check("arst_cdw", 64'(m_cdw), 64'd0);
        check("arst_mb",  64'(m_mb),  64'd0);
        #13 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        push(36'o707, 36'o0, 23'o7000, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
        start(1'b1, 1'b0, 1'b0, 23'o7000, 1'b0, 36'o0, 36'o707);
        #0 mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        wait_idle("post_reset_idle");
        repeat (5) @(posedge clk);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
